// File: rtl/correlator_pkg.sv
//--------------------------------------------------------------------
// Module : correlator_pkg
// Brief  : Shared register map, FSM states and helpers for the
//          correlator host controller.
// Rev    : 1.0  initial release
//--------------------------------------------------------------------
`default_nettype none

package correlator_pkg;

   localparam logic [6:0] c_addrWinLen  = 7'h00;
   localparam logic [6:0] c_addrShape   = 7'h01;
   localparam logic [6:0] c_addrPeriod  = 7'h02;
   localparam logic [6:0] c_addrJitter  = 7'h03;
   localparam logic [6:0] c_addrPwm     = 7'h04;
   localparam logic [6:0] c_addrSeed    = 7'h05;
   localparam logic [6:0] c_addrFlush   = 7'h06;
   localparam logic [6:0] c_addrBurst   = 7'h07;
   localparam logic [6:0] c_addrVersion = 7'h7F;

   localparam logic [7:0] c_versionDefault = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WR_DATA    = 3'd1,
      ST_RD_RESP    = 3'd2,
      ST_BURST_LEN  = 3'd3,
      ST_BURST_HDR  = 3'd4,
      ST_BURST_DATA = 3'd5
   } hostState_t;

   function automatic logic [7:0] satByte(input logic [7:0] value, input logic [7:0] maxValue);
      return (value > maxValue) ? maxValue : value;
   endfunction

endpackage

`default_nettype wire

// File: rtl/hostctrl_outreg.sv
//--------------------------------------------------------------------
// Module : hostctrl_outreg
// Brief  : One-entry valid/ready holding register for the host byte pipe.
// Rev    : 1.0  initial release
//--------------------------------------------------------------------
`default_nettype none

module hostctrl_outreg (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_cg,
   input  logic       i_load,
   input  logic [7:0] i_loadData,
   input  logic       i_ready,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_free
);

   logic [7:0] r_data;
   logic       r_valid;

   // Free when empty or being consumed this cycle, so a reload lands without a bubble.
   assign o_free  = !r_valid || i_ready;
   assign o_data  = r_data;
   assign o_valid = r_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data  <= 8'h00;
         r_valid <= 1'b0;
      end else if (i_cg) begin
         if (i_load) begin
            r_data  <= i_loadData;
            r_valid <= 1'b1;
         end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/correlator_hostctrl.sv
//--------------------------------------------------------------------
// Module : correlator_hostctrl
// Brief  : Host byte-stream command parser, correlator config owner and
//          pktfifo burst drainer.
// Rev    : 1.0  initial release
//--------------------------------------------------------------------
`default_nettype none

module correlator_hostctrl
   import correlator_pkg::*;
#(
   parameter int         MAX_WINDOW_LENGTH_EXP = 16,
   parameter int         MAX_SAMPLE_PERIOD_EXP = 15,
   parameter int         MAX_SAMPLE_JITTER_EXP = 8,
   parameter int         PKTFIFO_DEPTH         = 50,
   parameter logic [7:0] VERSION               = c_versionDefault
) (
   input  logic                                       i_clk,
   input  logic                                       i_rst_n,
   input  logic                                       i_cg,
   input  logic [7:0]                                 i_in_data,
   input  logic                                       i_in_valid,
   output logic                                       o_in_ready,
   output logic [7:0]                                 o_out_data,
   output logic                                       o_out_valid,
   input  logic                                       i_out_ready,
   output logic [$clog2(MAX_WINDOW_LENGTH_EXP+1)-1:0] o_windowLengthExp,
   output logic                                       o_windowShape,
   output logic [$clog2(MAX_SAMPLE_PERIOD_EXP+1)-1:0] o_samplePeriodExp,
   output logic [$clog2(MAX_SAMPLE_JITTER_EXP+1)-1:0] o_sampleJitterExp,
   output logic [2:0]                                 o_pwmSelect,
   output logic                                       o_wr_samplePeriod,
   output logic [7:0]                                 o_jitterSeedByte,
   output logic                                       o_jitterSeedValid,
   output logic                                       o_pktfifo_flush,
   output logic                                       o_pktfifo_pop,
   input  logic [7:0]                                 i_pktfifo_data,
   input  logic                                       i_pktfifo_empty,
   input  logic [$clog2(PKTFIFO_DEPTH+1)-1:0]         i_pktfifo_nEntries
);

   localparam int WL_W = $clog2(MAX_WINDOW_LENGTH_EXP+1);
   localparam int SP_W = $clog2(MAX_SAMPLE_PERIOD_EXP+1);
   localparam int SJ_W = $clog2(MAX_SAMPLE_JITTER_EXP+1);

   hostState_t r_state;
   logic       r_inReady;
   logic [6:0] r_wrAddr;
   logic [7:0] r_remaining;
   logic       r_flush;

   logic       w_accept;
   logic       w_handshake;
   logic       w_outFree;
   logic       w_pop;
   logic [7:0] w_nEntries8;
   logic [7:0] w_burstN;
   logic [7:0] w_rdByte;
   logic       w_load;
   logic [7:0] w_loadData;

   assign o_in_ready      = r_inReady;
   assign o_pktfifo_flush = r_flush && i_cg;
   assign o_pktfifo_pop   = w_pop;

   assign w_accept    = i_cg && i_in_valid && r_inReady;
   assign w_handshake = i_cg && o_out_valid && i_out_ready;
   assign w_nEntries8 = 8'(i_pktfifo_nEntries);
   assign w_burstN    = (i_in_data < w_nEntries8) ? i_in_data : w_nEntries8;

   // The header handshake may already pop the first payload byte.
   assign w_pop = i_cg && ((r_state == ST_BURST_HDR) || (r_state == ST_BURST_DATA)) &&
                  (r_remaining != 8'd0) && !i_pktfifo_empty && w_outFree;

   always_comb begin
      w_rdByte = 8'h00;
      case (i_in_data[6:0])
         c_addrWinLen:  w_rdByte = 8'(o_windowLengthExp);
         c_addrShape:   w_rdByte = {7'd0, o_windowShape};
         c_addrPeriod:  w_rdByte = 8'(o_samplePeriodExp);
         c_addrJitter:  w_rdByte = 8'(o_sampleJitterExp);
         c_addrPwm:     w_rdByte = {5'd0, o_pwmSelect};
         c_addrVersion: w_rdByte = VERSION;
         default:       w_rdByte = 8'h00;
      endcase
   end

   always_comb begin
      w_load     = 1'b0;
      w_loadData = 8'h00;
      if (w_pop) begin
         w_load     = 1'b1;
         w_loadData = i_pktfifo_data;
      end else if (w_accept && (r_state == ST_IDLE) && i_in_data[7] &&
                   (i_in_data[6:0] != c_addrBurst)) begin
         w_load     = 1'b1;
         w_loadData = w_rdByte;
      end else if (w_accept && (r_state == ST_BURST_LEN)) begin
         w_load     = 1'b1;
         w_loadData = w_burstN;
      end
   end

   hostctrl_outreg u_outreg (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_cg       (i_cg),
      .i_load     (w_load),
      .i_loadData (w_loadData),
      .i_ready    (i_out_ready),
      .o_data     (o_out_data),
      .o_valid    (o_out_valid),
      .o_free     (w_outFree)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state           <= ST_IDLE;
         r_inReady         <= 1'b0;
         r_wrAddr          <= 7'd0;
         r_remaining       <= 8'd0;
         r_flush           <= 1'b0;
         o_windowLengthExp <= '0;
         o_windowShape     <= 1'b0;
         o_samplePeriodExp <= '0;
         o_sampleJitterExp <= '0;
         o_pwmSelect       <= 3'd0;
         o_wr_samplePeriod <= 1'b0;
         o_jitterSeedByte  <= 8'h00;
         o_jitterSeedValid <= 1'b0;
      end else if (i_cg) begin
         o_wr_samplePeriod <= 1'b0;
         o_jitterSeedValid <= 1'b0;
         r_flush           <= 1'b0;
         if (w_pop) r_remaining <= r_remaining - 8'd1;
         case (r_state)
            ST_IDLE: begin
               r_inReady <= 1'b1;
               if (w_accept) begin
                  if (!i_in_data[7]) begin
                     r_wrAddr <= i_in_data[6:0];
                     r_state  <= ST_WR_DATA;
                  end else if (i_in_data[6:0] == c_addrBurst) begin
                     r_state <= ST_BURST_LEN;
                  end else begin
                     r_inReady <= 1'b0;
                     r_state   <= ST_RD_RESP;
                  end
               end
            end
            ST_WR_DATA: begin
               if (w_accept) begin
                  case (r_wrAddr)
                     c_addrWinLen: o_windowLengthExp <= WL_W'(satByte(i_in_data, 8'(MAX_WINDOW_LENGTH_EXP)));
                     c_addrShape:  o_windowShape     <= i_in_data[0];
                     c_addrPeriod: begin
                        o_samplePeriodExp <= SP_W'(satByte(i_in_data, 8'(MAX_SAMPLE_PERIOD_EXP)));
                        o_wr_samplePeriod <= 1'b1;
                     end
                     c_addrJitter: o_sampleJitterExp <= SJ_W'(satByte(i_in_data, 8'(MAX_SAMPLE_JITTER_EXP)));
                     c_addrPwm:    o_pwmSelect       <= i_in_data[2:0];
                     c_addrSeed: begin
                        o_jitterSeedByte  <= i_in_data;
                        o_jitterSeedValid <= 1'b1;
                     end
                     c_addrFlush:  r_flush <= 1'b1;
                     default:      ;
                  endcase
                  r_state <= ST_IDLE;
               end
            end
            ST_RD_RESP: begin
               if (w_handshake) begin
                  r_inReady <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            ST_BURST_LEN: begin
               if (w_accept) begin
                  r_remaining <= w_burstN;
                  r_inReady   <= 1'b0;
                  r_state     <= ST_BURST_HDR;
               end
            end
            ST_BURST_HDR: begin
               if (w_handshake) begin
                  if (r_remaining == 8'd0) begin
                     r_inReady <= 1'b1;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_state <= ST_BURST_DATA;
                  end
               end
            end
            ST_BURST_DATA: begin
               // With nothing left to pop, the byte being consumed is the last one.
               if ((r_remaining == 8'd0) && w_handshake) begin
                  r_inReady <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_inReady <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_correlator_hostctrl.sv
//--------------------------------------------------------------------
// Module : tb_correlator_hostctrl
// Brief  : Scoreboard bench for the correlator host controller.
// Rev    : 1.0  initial release
//--------------------------------------------------------------------
`default_nettype none

module tb_correlator_hostctrl;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       cg = 1'b1;
   logic [7:0] inData = 8'h00;
   logic       inValid = 1'b0;
   logic       inReady;
   logic [7:0] outData;
   logic       outValid;
   logic       outReady = 1'b1;
   logic [4:0] windowLengthExp;
   logic       windowShape;
   logic [3:0] samplePeriodExp;
   logic [3:0] sampleJitterExp;
   logic [2:0] pwmSelect;
   logic       wrSamplePeriod;
   logic [7:0] jitterSeedByte;
   logic       jitterSeedValid;
   logic       pktfifoFlush;
   logic       pktfifoPop;
   logic [7:0] fifoData = 8'h00;
   logic       fifoEmpty = 1'b1;
   logic [5:0] fifoCount = 6'd0;

   int   vectors = 0;
   int   miscompares = 0;
   logic [7:0] expQ[$];
   logic [7:0] fifoQ[$];
   int   popCount = 0, wrCnt = 0, seedCnt = 0, flushCnt = 0;
   logic [7:0] seedSeen = 8'h00;
   logic popAtNeg = 1'b0;
   logic randReady = 1'b0;

   always #5 clk = ~clk;

   correlator_hostctrl dut (
      .i_clk              (clk),
      .i_rst_n            (rstN),
      .i_cg               (cg),
      .i_in_data          (inData),
      .i_in_valid         (inValid),
      .o_in_ready         (inReady),
      .o_out_data         (outData),
      .o_out_valid        (outValid),
      .i_out_ready        (outReady),
      .o_windowLengthExp  (windowLengthExp),
      .o_windowShape      (windowShape),
      .o_samplePeriodExp  (samplePeriodExp),
      .o_sampleJitterExp  (sampleJitterExp),
      .o_pwmSelect        (pwmSelect),
      .o_wr_samplePeriod  (wrSamplePeriod),
      .o_jitterSeedByte   (jitterSeedByte),
      .o_jitterSeedValid  (jitterSeedValid),
      .o_pktfifo_flush    (pktfifoFlush),
      .o_pktfifo_pop      (pktfifoPop),
      .i_pktfifo_data     (fifoData),
      .i_pktfifo_empty    (fifoEmpty),
      .i_pktfifo_nEntries (fifoCount)
   );

   task automatic checkVector(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic refreshFifo();
      fifoData  = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
      fifoEmpty = (fifoQ.size() == 0);
      fifoCount = 6'(fifoQ.size());
   endtask

   task automatic fillFifo(input int n);
      fifoQ.delete();
      for (int i = 0; i < n; i++) fifoQ.push_back(8'($urandom_range(0, 255)));
      refreshFifo();
   endtask

   // Scoreboard side: every consumed output byte is compared with the queue head.
   always @(negedge clk) begin
      if (rstN && cg && outValid && outReady) begin
         if (expQ.size() == 0) checkVector("spuriousOut", 32'(expQ.size()), 1);
         else                  checkVector("outByte", {24'd0, outData}, {24'd0, expQ.pop_front()});
      end
      if (pktfifoPop) checkVector("popWhileEmpty", {31'd0, fifoEmpty}, 0);
      popAtNeg = pktfifoPop;
      if (rstN) begin
         if (wrSamplePeriod) wrCnt++;
         if (jitterSeedValid) begin seedCnt++; seedSeen = jitterSeedByte; end
         if (pktfifoFlush) flushCnt++;
      end
   end

   always @(posedge clk) begin
      #1;
      if (popAtNeg && fifoQ.size() > 0) begin
         popCount++;
         void'(fifoQ.pop_front());
         refreshFifo();
      end
      outReady = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   task automatic sendByte(input logic [7:0] b);
      int t = 0;
      @(negedge clk);
      inData  = b;
      inValid = 1'b1;
      while (!inReady) begin
         @(negedge clk);
         t++;
         if (t > 200) begin
            checkVector("inReadyTimeout", {31'd0, inReady}, 1);
            break;
         end
      end
      @(posedge clk);
      #1 inValid = 1'b0;
   endtask

   task automatic writeReg(input logic [6:0] addr, input logic [7:0] value);
      sendByte({1'b0, addr});
      sendByte(value);
      repeat (3) @(negedge clk);
   endtask

   task automatic waitDrain();
      int t = 0;
      while (expQ.size() != 0 || !inReady || outValid) begin
         @(negedge clk);
         t++;
         if (t > 2000) begin
            checkVector("drainTimeout", 32'(expQ.size()), 0);
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic readReg(input logic [6:0] addr, input logic [7:0] exp);
      expQ.push_back(exp);
      sendByte({1'b1, addr});
      waitDrain();
   endtask

   task automatic runBurst(input logic [7:0] len);
      int n = (int'(len) < fifoQ.size()) ? int'(len) : fifoQ.size();
      int pops0 = popCount;
      expQ.push_back(8'(n));
      for (int i = 0; i < n; i++) expQ.push_back(fifoQ[i]);
      sendByte(8'h87);
      sendByte(len);
      waitDrain();
      checkVector("burstPops", 32'(popCount - pops0), 32'(n));
   endtask

   initial begin
      int c0;
      repeat (3) @(negedge clk);
      checkVector("rstInReady", {31'd0, inReady}, 0);
      checkVector("rstOutValid", {31'd0, outValid}, 0);
      checkVector("rstWinLen", {27'd0, windowLengthExp}, 0);
      rstN = 1'b1;
      repeat (3) @(negedge clk);
      checkVector("idleInReady", {31'd0, inReady}, 1);

      // Saturating writes and register readback
      writeReg(7'h00, 8'h20);
      checkVector("winLenSat", {27'd0, windowLengthExp}, 16);
      readReg(7'h00, 8'h10);
      writeReg(7'h01, 8'h03);
      checkVector("shape", {31'd0, windowShape}, 1);
      writeReg(7'h03, 8'hFF);
      checkVector("jitterSat", {28'd0, sampleJitterExp}, 8);
      writeReg(7'h04, 8'hFE);
      checkVector("pwmLowBits", {29'd0, pwmSelect}, 6);
      readReg(7'h04, 8'h06);
      readReg(7'h7F, 8'h01);
      readReg(7'h10, 8'h00);
      writeReg(7'h7F, 8'h55);
      readReg(7'h7F, 8'h01);

      // Strobes
      c0 = wrCnt;
      writeReg(7'h02, 8'h05);
      checkVector("periodExp", {28'd0, samplePeriodExp}, 5);
      checkVector("wrPeriodPulse", 32'(wrCnt - c0), 1);
      c0 = seedCnt;
      writeReg(7'h05, 8'hA5);
      checkVector("seedPulse", 32'(seedCnt - c0), 1);
      checkVector("seedByte", {24'd0, seedSeen}, 8'hA5);
      readReg(7'h05, 8'h00);
      c0 = flushCnt;
      writeReg(7'h06, 8'h01);
      checkVector("flushPulse", 32'(flushCnt - c0), 1);

      // Clock gate holds everything
      c0 = wrCnt;
      @(negedge clk);
      cg = 1'b0; inData = 8'h02; inValid = 1'b1;
      repeat (4) @(negedge clk);
      inValid = 1'b0; cg = 1'b1;
      repeat (2) @(negedge clk);
      writeReg(7'h02, 8'h09);
      checkVector("cgPeriod", {28'd0, samplePeriodExp}, 9);
      checkVector("cgWrPulse", 32'(wrCnt - c0), 1);

      // Bursts
      fillFifo(10); runBurst(8'd4);
      checkVector("fifoLeft", 32'(fifoQ.size()), 6);
      fillFifo(3);  runBurst(8'd8);
      fillFifo(0);  runBurst(8'd5);
      randReady = 1'b1;
      fillFifo(30); runBurst(8'd20);
      fillFifo(12); runBurst(8'd255);

      // Reset in the middle of a burst
      fillFifo(20);
      expQ.push_back(8'd20);
      for (int i = 0; i < 20; i++) expQ.push_back(fifoQ[i]);
      sendByte(8'h87);
      sendByte(8'd20);
      repeat (8) @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      checkVector("midRstOutValid", {31'd0, outValid}, 0);
      checkVector("midRstWinLen", {27'd0, windowLengthExp}, 0);
      checkVector("midRstPeriod", {28'd0, samplePeriodExp}, 0);
      checkVector("midRstPop", {31'd0, pktfifoPop}, 0);
      expQ.delete();
      randReady = 1'b0;
      fillFifo(0);
      repeat (2) @(negedge clk);
      rstN = 1'b1;
      repeat (3) @(negedge clk);
      checkVector("postRstInReady", {31'd0, inReady}, 1);
      readReg(7'h02, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL globalTimeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
